// File: rtl/core_run_controller.sv
// Run/halt sequencer for the single-cycle RV64 datapath: gates commits, handles
// start/step/halt/clear, PC breakpoint, ebreak, fault capture and run counters.
module core_run_controller #(
  parameter int unsigned PC_W  = 64,
  parameter int unsigned CNT_W = 32
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             start,
  input  logic             step,
  input  logic             halt_req,
  input  logic             clear,
  input  logic [PC_W-1:0]  pc,
  input  logic             is_ebreak,
  input  logic [4:0]       inv_flags,
  input  logic             bp_en,
  input  logic [PC_W-1:0]  bp_addr,
  output logic             commit_en,
  output logic             core_rst,
  output logic [2:0]       state,
  output logic [2:0]       halt_cause,
  output logic [4:0]       fault_code,
  output logic [PC_W-1:0]  fault_pc,
  output logic [CNT_W-1:0] retired,
  output logic [CNT_W-1:0] cycles
);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_RUN    = 3'd1,
    S_STEP   = 3'd2,
    S_HALTED = 3'd3,
    S_FAULT  = 3'd4
  } state_t;

  localparam logic [2:0]       CAUSE_NONE = 3'd0;
  localparam logic [2:0]       CAUSE_HALT = 3'd1;
  localparam logic [2:0]       CAUSE_STEP = 3'd2;
  localparam logic [2:0]       CAUSE_BP   = 3'd3;
  localparam logic [2:0]       CAUSE_EBRK = 3'd4;
  localparam logic [CNT_W-1:0] CNT_MAX    = '1;

  state_t            state_q, state_d;
  logic              core_rst_d;
  logic [2:0]        cause_d;
  logic [4:0]        fcode_d;
  logic [PC_W-1:0]   fpc_d;
  logic [CNT_W-1:0]  retired_d, cycles_d;
  logic              bp_skip_q, bp_skip_d;
  logic              active_c, fault_c, bp_hit_c;

  // Commit gating is combinational so the datapath sees it in the same cycle.
  always_comb begin
    active_c  = ((state_q == S_RUN) || (state_q == S_STEP)) && !clear;
    fault_c   = |inv_flags;
    bp_hit_c  = bp_en && (pc == bp_addr) && !bp_skip_q;
    commit_en = active_c && !fault_c && !bp_hit_c && !is_ebreak;
  end

  // Next-state, capture and counter logic.
  always_comb begin
    state_d    = state_q;
    core_rst_d = 1'b0;
    cause_d    = halt_cause;
    fcode_d    = fault_code;
    fpc_d      = fault_pc;
    bp_skip_d  = commit_en ? 1'b0 : bp_skip_q;
    retired_d  = (commit_en && (retired != CNT_MAX)) ? retired + CNT_W'(1) : retired;
    cycles_d   = (active_c && (cycles != CNT_MAX)) ? cycles + CNT_W'(1) : cycles;

    if (clear) begin
      state_d    = S_IDLE;
      core_rst_d = 1'b1;
      cause_d    = CAUSE_NONE;
      fcode_d    = 5'd0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (start) begin
            state_d = S_RUN;
            cause_d = CAUSE_NONE;
          end else if (step) begin
            state_d = S_STEP;
            cause_d = CAUSE_NONE;
          end
        end
        S_RUN, S_STEP: begin
          if (fault_c) begin
            state_d = S_FAULT;
            fcode_d = inv_flags;
            fpc_d   = pc;
          end else if (bp_hit_c) begin
            state_d = S_HALTED;
            cause_d = CAUSE_BP;
          end else if (is_ebreak) begin
            state_d = S_HALTED;
            cause_d = CAUSE_EBRK;
          end else if ((state_q == S_RUN) && halt_req) begin
            state_d = S_HALTED;
            cause_d = CAUSE_HALT;
          end else if (state_q == S_STEP) begin
            state_d = S_HALTED;
            cause_d = CAUSE_STEP;
          end
        end
        S_HALTED: begin
          // Resuming skips the breakpoint once so we can step off the bp PC.
          if (start) begin
            state_d   = S_RUN;
            cause_d   = CAUSE_NONE;
            bp_skip_d = 1'b1;
          end else if (step) begin
            state_d   = S_STEP;
            cause_d   = CAUSE_NONE;
            bp_skip_d = 1'b1;
          end
        end
        S_FAULT: state_d = S_FAULT;
        default: state_d = S_IDLE;
      endcase
    end
  end

  // State and output registers.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q    <= S_IDLE;
      core_rst   <= 1'b0;
      halt_cause <= CAUSE_NONE;
      fault_code <= 5'd0;
      fault_pc   <= '0;
      retired    <= '0;
      cycles     <= '0;
      bp_skip_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      core_rst   <= core_rst_d;
      halt_cause <= cause_d;
      fault_code <= fcode_d;
      fault_pc   <= fpc_d;
      retired    <= retired_d;
      cycles     <= cycles_d;
      bp_skip_q  <= bp_skip_d;
    end
  end

  assign state = state_q;

endmodule
